// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit adder that sums CHUNK bits per
// clock and ripples the carry through a register between slices, trading
// latency for a short carry path. Handshake is start/busy/done.
// Optional feature macro: CHUNKED_SERIAL_ADDER_OVF_EN adds the registered
// signed-overflow output "ovf".
module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   // A width that does not split into whole slices cannot be built
   generate
      if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
         $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [CHUNK-1:0] sliceA;
   logic [CHUNK-1:0] sliceB;
   logic [CHUNK:0]   sliceTotal;
   logic [WIDTH-1:0] workMerged;

   // Add the current slice and build the work word with that slice inserted
   always_comb begin
      sliceA     = opA_q[idx_q*CHUNK +: CHUNK];
      sliceB     = opB_q[idx_q*CHUNK +: CHUNK];
      sliceTotal = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK{1'b0}}, carry_q};
      workMerged = work_q;
      workMerged[idx_q*CHUNK +: CHUNK] = sliceTotal[CHUNK-1:0];
   end

   // Next-state logic: latch operands on start, step one slice per cycle,
   // publish the result only on the edge that finishes the last slice
   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ADD;
               opA_d   = a;
               opB_d   = b;
               carry_d = cin;
               idx_d   = '0;
            end
         end
         ADD: begin
            work_d  = workMerged;
            carry_d = sliceTotal[CHUNK];
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               idx_d   = '0;
               sum_d   = workMerged;
               cout_d  = sliceTotal[CHUNK];
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
               ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                         (workMerged[WIDTH-1] != opA_q[WIDTH-1]);
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == ADD);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed vector table plus hand-written multi-cycle
// sequences for the chunked serial adder (16/4 and 8/8 instances).
module tb_chunked_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   logic        start8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        cin8;
   logic        busy8;
   logic        done8;
   logic [7:0]  sum8;
   logic        cout8;
   logic        ovf8;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] expSum;
      logic        expCout;
      logic        expOvf;
   } vec_t;

   vec_t vecs[8];

   // Free-running 100 MHz clock shared by both instances
   always #5 clk = ~clk;

   chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
      .ovf   (ovf8),
`endif
      .cout  (cout8)
   );

`ifndef CHUNKED_SERIAL_ADDER_OVF_EN
   assign ovf  = 1'b0;
   assign ovf8 = 1'b0;
`endif

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Launch one operation on the 16-bit instance and wait (bounded) for done.
   // Leaves the caller at the falling edge of the done cycle.
   task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                input logic tcin, output int busyCycles,
                                output bit gotDone, output int protoErr);
      logic [15:0] prevSum;
      @(negedge clk);
      prevSum = sum;
      a = ta; b = tb; cin = tcin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busyCycles = 0;
      gotDone    = 1'b0;
      protoErr   = 0;
      for (int i = 0; i < 20 && !gotDone; i++) begin
         if (busy && done) protoErr++;
         if (busy) begin
            busyCycles++;
            if (sum !== prevSum) protoErr++;
         end
         if (done) gotDone = 1'b1;
         else @(negedge clk);
      end
   endtask

   int          busyCycles;
   bit          gotDone;
   int          protoErr;
   int          doneSeen;
   logic [15:0] ra;
   logic [15:0] rb;
   logic        rc;
   logic [16:0] ref17;
   logic        refOvf;

   initial begin
      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset sum", sum, 0);
      checkOutput("reset cout", cout, 0);
      checkOutput("reset ovf", ovf, 0);
      checkOutput("reset busy8", busy8, 0);

      // Directed table
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, busyCycles, gotDone, protoErr);
         checkOutput($sformatf("vec%0d done", i), gotDone, 1);
         checkOutput($sformatf("vec%0d busycycles", i), busyCycles, 4);
         checkOutput($sformatf("vec%0d protocol", i), protoErr, 0);
         checkOutput($sformatf("vec%0d sum", i), sum, vecs[i].expSum);
         checkOutput($sformatf("vec%0d cout", i), cout, vecs[i].expCout);
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
         checkOutput($sformatf("vec%0d ovf", i), ovf, vecs[i].expOvf);
`endif
      end

      // done is a single-cycle pulse and the result holds afterwards
      @(negedge clk);
      checkOutput("done pulse width", done, 0);
      checkOutput("sum hold after done", sum, 16'hFFFF);

      // start held high while busy with changing operands is ignored
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      busyCycles = 0;
      gotDone    = 1'b0;
      for (int i = 0; i < 20 && !gotDone; i++) begin
         @(negedge clk);
         if (busy) busyCycles++;
         if (done) begin
            gotDone = 1'b1;
            start   = 1'b0;
         end else begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         end
      end
      checkOutput("restart done", gotDone, 1);
      checkOutput("restart busycycles", busyCycles, 4);
      checkOutput("restart sum", sum, 16'h3333);
      checkOutput("restart cout", cout, 0);
      @(negedge clk);
      checkOutput("idle after done", busy, 0);

      // Reset during the second ADD cycle aborts the operation
      a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", busy, 0);
      checkOutput("abort done", done, 0);
      checkOutput("abort sum", sum, 0);
      checkOutput("abort cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) doneSeen++;
      end
      checkOutput("abort no done", doneSeen, 0);
      applyStimulus(16'h0F0F, 16'h00F1, 1'b0, busyCycles, gotDone, protoErr);
      checkOutput("post-abort done", gotDone, 1);
      checkOutput("post-abort sum", sum, 16'h1000);

      // Single-slice instance: one ADD cycle
      @(negedge clk);
      a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("w8 busy", busy8, 1);
      checkOutput("w8 early done", done8, 0);
      @(negedge clk);
      checkOutput("w8 done", done8, 1);
      checkOutput("w8 busy low", busy8, 0);
      checkOutput("w8 sum", sum8, 8'h2C);
      checkOutput("w8 cout", cout8, 1);
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
      checkOutput("w8 ovf", ovf8, 0);
`endif

      // Random operands against an arithmetic reference
      for (int n = 0; n < 200; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         ref17  = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         refOvf = (ra[15] == rb[15]) && (ref17[15] != ra[15]);
         applyStimulus(ra, rb, rc, busyCycles, gotDone, protoErr);
         checkOutput($sformatf("rand%0d result", n), {gotDone, cout, sum}, {1'b1, ref17});
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
         checkOutput($sformatf("rand%0d ovf", n), ovf, refOvf);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
